// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and the forwarding compare used by the hazard unit.
package hazard_pkg;
    localparam int REG_W = 5;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
    typedef enum logic {HZ_RUN, HZ_WAIT} hz_state_t;
    function automatic fwd_sel_t fwd_pick(input logic [REG_W-1:0] rs, rd_m, rd_w, input logic wr_m, wr_w);
        return (wr_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
               (wr_w && rd_w != '0 && rd_w == rs) ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side register/control signals seen by the hazard unit.
interface hazard_unit_if #(parameter int CNT_W = 32);
    import hazard_pkg::*;
    logic [REG_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]       result_src_e;
    logic [2:0]       reg_write_m, reg_write_w;
    logic             pc_src_e, mem_req_m, mem_ack_m;
    logic             en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, mem_timeout;
    fwd_sel_t         forward_a_e, forward_b_e;
    logic [CNT_W-1:0] stall_count;
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, result_src_e,
               reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ack_m,
        input  en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, mem_timeout,
               forward_a_e, forward_b_e, stall_count
    );
    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, result_src_e,
               reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ack_m,
        output en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, mem_timeout,
               forward_a_e, forward_b_e, stall_count
    );
endinterface

// File: rtl/hazard_unit_forward_sel.sv
// forward_sel: picks the ALU operand source for one Execute-stage source register.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rd_m,
    input  logic [REG_W-1:0] i_rd_w,
    input  logic [2:0]       i_reg_write_m,
    input  logic [2:0]       i_reg_write_w,
    output fwd_sel_t         o_sel
);
    assign o_sel = fwd_pick(i_rs, i_rd_m, i_rd_w, |i_reg_write_m, |i_reg_write_w);
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use stall, branch flush and memory-wait freeze control
// for the 5-stage pipeline.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic         clk,
    input logic         rst,
    hazard_unit_if.slave hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MEM_TIMEOUT);

    hz_state_t        r_state, w_next;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    fwd_sel_t         w_fwd_a, w_fwd_b;
    logic             w_lw_stall, w_freeze, w_en_f, w_wait_miss;

    forward_sel u_fwd_a (
        .i_rs(hz.rs1_e), .i_rd_m(hz.rd_m), .i_rd_w(hz.rd_w),
        .i_reg_write_m(hz.reg_write_m), .i_reg_write_w(hz.reg_write_w), .o_sel(w_fwd_a)
    );
    forward_sel u_fwd_b (
        .i_rs(hz.rs2_e), .i_rd_m(hz.rd_m), .i_rd_w(hz.rd_w),
        .i_reg_write_m(hz.reg_write_m), .i_reg_write_w(hz.reg_write_w), .o_sel(w_fwd_b)
    );

    assign w_lw_stall = hz.result_src_e == RESULT_SRC_LOAD && hz.rd_e != '0 &&
                        (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);

    // An access acked in the same cycle it is issued never freezes.
    always_comb begin
        w_freeze = (r_state == HZ_RUN) ? (hz.mem_req_m && !hz.mem_ack_m) : !hz.mem_ack_m;
        w_next   = w_freeze ? HZ_WAIT : HZ_RUN;
    end

    assign w_wait_miss = r_state == HZ_WAIT && !hz.mem_ack_m;
    assign w_en_f      = !w_freeze && !w_lw_stall;

    assign hz.en_f        = rst || w_en_f;
    assign hz.en_d        = rst || w_en_f;
    assign hz.en_e        = rst || !w_freeze;
    assign hz.en_m        = rst || !w_freeze;
    assign hz.en_w        = rst || !w_freeze;
    assign hz.flush_d     = rst || (hz.pc_src_e && !w_freeze);
    assign hz.flush_e     = rst || ((hz.pc_src_e || w_lw_stall) && !w_freeze);
    assign hz.forward_a_e = rst ? FWD_RF : w_fwd_a;
    assign hz.forward_b_e = rst ? FWD_RF : w_fwd_b;
    assign hz.mem_timeout = r_timeout;
    assign hz.stall_count = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HZ_RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= !w_wait_miss ? '0 : (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
            if (w_wait_miss && r_wait_cnt >= WAIT_LAST)
                r_timeout <= 1'b1;
            if (!w_en_f && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit forwarding, stalls, flushes and memory freeze.
module tb_hazard_unit;
    import hazard_pkg::*;

    typedef logic [11:0] vec_t;
    typedef struct packed {
        logic [4:0] rs1e, rs2e, rdm;
        logic [2:0] wm;
        logic [4:0] rdw;
        logic [2:0] ww;
        logic [1:0] fa, fb;
    } fc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    vec_t sb[$];
    vec_t e;

    hazard_unit_if #(.CNT_W(32)) hz();
    hazard_unit #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(hz));

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] fa, fb, input logic to);
        return {en, fl, fa, fb, to};
    endfunction

    function automatic vec_t obs();
        return {hz.en_f, hz.en_d, hz.en_e, hz.en_m, hz.en_w, hz.flush_d, hz.flush_e,
                hz.forward_a_e, hz.forward_b_e, hz.mem_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_in();
        {hz.rs1_d, hz.rs2_d, hz.rs1_e, hz.rs2_e, hz.rd_e, hz.rd_m, hz.rd_w} = '0;
        hz.result_src_e = 2'b00;
        hz.reg_write_m = 3'b0;
        hz.reg_write_w = 3'b0;
        hz.pc_src_e = 1'b0;
        hz.mem_req_m = 1'b0;
        hz.mem_ack_m = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hz.rd_m = 5; hz.reg_write_m = 1; hz.rs1_e = 5; hz.rs2_e = 5; hz.pc_src_e = 1;
        hz.result_src_e = 2'b01; hz.rd_e = 3; hz.rs1_d = 3; hz.mem_req_m = 1; hz.mem_ack_m = 0;
        tick();
        sb.push_back(v(5'b11111, 2'b11, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), e); end
        total++;
        if (hz.stall_count !== 32'd0) begin bad++; $display("FAIL reset_stallcount got=%0d want=0", hz.stall_count); end
        do_reset();
    endtask

    task automatic test_forward();
        fc_t cs [6] = '{
            '{5'd5, 5'd0, 5'd5, 3'd1, 5'd5, 3'd1, 2'b10, 2'b00},
            '{5'd5, 5'd0, 5'd0, 3'd1, 5'd5, 3'd1, 2'b01, 2'b00},
            '{5'd5, 5'd5, 5'd5, 3'd0, 5'd5, 3'd4, 2'b01, 2'b01},
            '{5'd9, 5'd9, 5'd9, 3'd2, 5'd9, 3'd1, 2'b10, 2'b10},
            '{5'd0, 5'd0, 5'd0, 3'd7, 5'd0, 3'd7, 2'b00, 2'b00},
            '{5'd3, 5'd4, 5'd4, 3'd1, 5'd3, 3'd0, 2'b00, 2'b10}
        };
        do_reset();
        for (int i = 0; i < 6; i++) begin
            hz.rs1_e = cs[i].rs1e; hz.rs2_e = cs[i].rs2e; hz.rd_m = cs[i].rdm;
            hz.reg_write_m = cs[i].wm; hz.rd_w = cs[i].rdw; hz.reg_write_w = cs[i].ww;
            sb.push_back(v(5'b11111, 2'b00, cs[i].fa, cs[i].fb, 1'b0));
            #1;
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL forward_%0d got=%h want=%h", i, obs(), e); end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        hz.result_src_e = 2'b01; hz.rd_e = 7; hz.rs2_d = 7;
        sb.push_back(v(5'b00111, 2'b01, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL loaduse_stall got=%h want=%h", obs(), e); end
        tick();
        clr_in();
        hz.rd_m = 7; hz.reg_write_m = 1; hz.rs2_e = 7; hz.rs2_d = 7;
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b10, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL loaduse_fwd got=%h want=%h", obs(), e); end
        total++;
        if (hz.stall_count !== 32'd1) begin bad++; $display("FAIL loaduse_count got=%0d want=1", hz.stall_count); end
        tick();
        clr_in();
        hz.result_src_e = 2'b10; hz.rd_e = 7; hz.rs1_d = 7;
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL nonload_nostall got=%h want=%h", obs(), e); end
        tick();
        clr_in();
    endtask

    task automatic test_mem_freeze();
        do_reset();
        hz.mem_req_m = 1; hz.mem_ack_m = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin hz.result_src_e = 2'b01; hz.rd_e = 4; hz.rs1_d = 4; hz.pc_src_e = 1; end
            sb.push_back(v(5'b00000, 2'b00, 2'b00, 2'b00, 1'b0));
            #1;
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL freeze_%0d got=%h want=%h", i, obs(), e); end
            tick();
        end
        clr_in();
        hz.mem_req_m = 1; hz.mem_ack_m = 1;
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL freeze_ack got=%h want=%h", obs(), e); end
        total++;
        if (hz.stall_count !== 32'd3) begin bad++; $display("FAIL freeze_count got=%0d want=3", hz.stall_count); end
        tick();
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL same_cycle_ack got=%h want=%h", obs(), e); end
        tick();
        clr_in();
    endtask

    task automatic test_branch_in_wait();
        do_reset();
        hz.mem_req_m = 1; hz.mem_ack_m = 0; hz.pc_src_e = 1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(v(5'b00000, 2'b00, 2'b00, 2'b00, 1'b0));
            #1;
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL branch_wait_%0d got=%h want=%h", i, obs(), e); end
            tick();
        end
        hz.mem_ack_m = 1;
        sb.push_back(v(5'b11111, 2'b11, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL branch_release got=%h want=%h", obs(), e); end
        tick();
        clr_in();
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL branch_after got=%h want=%h", obs(), e); end
        tick();
        hz.result_src_e = 2'b01; hz.rd_e = 7; hz.rs1_d = 7; hz.pc_src_e = 1;
        sb.push_back(v(5'b00111, 2'b11, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL lw_and_branch got=%h want=%h", obs(), e); end
        tick();
        clr_in();
    endtask

    task automatic test_timeout();
        do_reset();
        hz.mem_req_m = 1; hz.mem_ack_m = 0;
        for (int i = 0; i < 20; i++) begin
            sb.push_back(v(5'b00000, 2'b00, 2'b00, 2'b00, i >= 17));
            #1;
            e = sb.pop_front();
            total++;
            if (obs() !== e) begin bad++; $display("FAIL timeout_cyc%0d got=%h want=%h", i, obs(), e); end
            tick();
        end
        hz.mem_ack_m = 1;
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b1));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL timeout_ack got=%h want=%h", obs(), e); end
        tick();
        clr_in();
        tick();
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b1));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL timeout_sticky got=%h want=%h", obs(), e); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL timeout_cleared got=%h want=%h", obs(), e); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        hz.mem_req_m = 1; hz.mem_ack_m = 0;
        tick();
        tick();
        rst = 1'b1;
        sb.push_back(v(5'b11111, 2'b11, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL midwait_rst got=%h want=%h", obs(), e); end
        tick();
        rst = 1'b0;
        clr_in();
        hz.result_src_e = 2'b01; hz.rd_e = 0; hz.rs1_d = 0; hz.rs2_d = 0;
        hz.rd_m = 0; hz.reg_write_m = 1; hz.rd_w = 0; hz.reg_write_w = 1;
        sb.push_back(v(5'b11111, 2'b00, 2'b00, 2'b00, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL midwait_after got=%h want=%h", obs(), e); end
        total++;
        if (hz.stall_count !== 32'd0) begin bad++; $display("FAIL midwait_count got=%0d want=0", hz.stall_count); end
        tick();
        clr_in();
    endtask

    initial begin
        clr_in();
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_mem_freeze();
        test_branch_in_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
